// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared pipeline constants, opcodes and the IF/ID bundle type.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [31:0] NOP_INST  = 32'h0000_0033;  // add x0,x0,x0
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_RTYPE  = 7'b0110011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
    } ifid_t;

    // Register contents after reset: a bubble whose pc fields read 0 / 4.
    localparam ifid_t IFID_RESET = '{pc: 32'd0, pc4: 32'd4, inst: NOP_INST, valid: 1'b0};

    // A bubble keeps the previous pc fields so downstream debug still sees
    // where the pipeline was; only the instruction and valid bit change.
    function automatic ifid_t ifid_bubble(input ifid_t prev);
        ifid_t b;
        b       = prev;
        b.inst  = NOP_INST;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_if
// Brief    : Control, instruction-memory and IF/ID bundle of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
interface if_stage_if #(
    parameter int ADDR_W = 6
);
    logic              stall_i;
    logic              flush_i;
    logic              redirect_i;
    logic [31:0]       redirect_pc_i;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_data_i;
    logic [31:0]       ifid_pc_o;
    logic [31:0]       ifid_pc4_o;
    logic [31:0]       ifid_inst_o;
    logic              ifid_valid_o;
    logic              misaligned_o;
    logic [31:0]       fetch_count_o;

    // Environment side: hazard unit, EX redirect, memory and decode.
    modport master (
        output stall_i, flush_i, redirect_i, redirect_pc_i, imem_data_i,
        input  imem_addr_o, ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o,
               misaligned_o, fetch_count_o
    );

    // Fetch-stage side.
    modport slave (
        input  stall_i, flush_i, redirect_i, redirect_pc_i, imem_data_i,
        output imem_addr_o, ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o,
               misaligned_o, fetch_count_o
    );
endinterface
`default_nettype wire

// File: rtl/if_stage_ifid_reg.sv
`default_nettype none
// ============================================================================
// Module   : ifid_reg
// Brief    : Pipeline register with load / hold / bubble controls.
//            Bubble has priority over load; neither means hold.
// Revision : 1.0 - initial release
// ============================================================================
module ifid_reg
    import cpu_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst_n,
    input  wire logic  load_i,
    input  wire logic  bubble_i,
    input  wire ifid_t d_i,
    output ifid_t      q_o
);

    ifid_t ifid_q;
    ifid_t ifid_d;

    // Next-state selection: bubble beats load, otherwise hold.
    always_comb begin
        ifid_d = ifid_q;
        if (bubble_i) begin
            ifid_d = ifid_bubble(ifid_q);
        end else if (load_i) begin
            ifid_d = d_i;
        end
    end

    // Storage with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifid_q <= IFID_RESET;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign q_o = ifid_q;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch: PC register, next-PC selection, fetch counter
//            and misaligned-redirect flag; feeds the IF/ID register.
//            Priority per edge: reset > redirect > flush > stall > normal.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  wire logic clk,
    input  wire logic rst_n,
    if_stage_if.slave bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic        misaligned_q, misaligned_d;
    logic        load, bubble;
    ifid_t       fetch_bundle;
    ifid_t       ifid_q;

    // Word address straight from the PC; upper PC bits alias silently.
    assign bus.imem_addr_o = pc_q[ADDR_W+1:2];

    assign fetch_bundle = '{pc:    pc_q,
                            pc4:   pc_q + 32'd4,
                            inst:  bus.imem_data_i,
                            valid: 1'b1};

    // Next-PC, IF/ID control, counter and sticky-flag selection.
    always_comb begin
        pc_d         = pc_q;
        count_d      = count_q;
        misaligned_d = misaligned_q;
        load         = 1'b0;
        bubble       = 1'b0;
        if (bus.redirect_i) begin
            pc_d   = {bus.redirect_pc_i[31:2], 2'b00};
            bubble = 1'b1;
            if (bus.redirect_pc_i[1:0] != 2'b00) begin
                misaligned_d = 1'b1;
            end
        end else if (bus.flush_i) begin
            bubble = 1'b1;
            if (!bus.stall_i) begin
                pc_d = pc_q + 32'd4;
            end
        end else if (!bus.stall_i) begin
            pc_d    = pc_q + 32'd4;
            load    = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    // PC, counter and misaligned flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            count_q      <= 32'd0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            count_q      <= count_d;
            misaligned_q <= misaligned_d;
        end
    end

    ifid_reg u_ifid_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .bubble_i (bubble),
        .d_i      (fetch_bundle),
        .q_o      (ifid_q)
    );

    assign bus.ifid_pc_o     = ifid_q.pc;
    assign bus.ifid_pc4_o    = ifid_q.pc4;
    assign bus.ifid_inst_o   = ifid_q.inst;
    assign bus.ifid_valid_o  = ifid_q.valid;
    assign bus.misaligned_o  = misaligned_q;
    assign bus.fetch_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage with a behavioural fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0033;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem [64];

    int total;
    int bad;

    // Reference state, derived from the fetch rules only.
    logic [31:0] m_pc, m_ipc, m_ipc4, m_inst, m_cnt;
    logic        m_valid, m_mis;

    if_stage_if #(.ADDR_W(6)) bus ();

    if_stage #(.ADDR_W(6), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign bus.imem_data_i = mem[bus.imem_addr_o];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model, land 1 time unit after the edge.
    task automatic step(input logic r, input logic s, input logic f,
                        input logic rd, input logic [31:0] rp);
        logic [7:0] byte_addr;
        rst_n             = r;
        bus.stall_i       = s;
        bus.flush_i       = f;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = rp;
        byte_addr         = m_pc[7:0];
        if (!r) begin
            m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h4; m_inst = NOP;
            m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
        end else if (rd) begin
            m_pc = rp & 32'hFFFF_FFFC;
            m_inst = NOP; m_valid = 1'b0;
            if (rp[1:0] != 2'b00) m_mis = 1'b1;
        end else if (f) begin
            m_inst = NOP; m_valid = 1'b0;
            if (!s) m_pc = m_pc + 32'd4;
        end else if (!s) begin
            m_ipc   = m_pc;
            m_ipc4  = m_pc + 32'd4;
            m_inst  = mem[byte_addr / 4];
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
            m_pc    = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h44);
        total++; if (bus.ifid_inst_o !== NOP) begin bad++; $display("FAIL rst_inst got=%h exp=%h", bus.ifid_inst_o, NOP); end
        total++; if (bus.ifid_pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", bus.ifid_pc_o); end
        total++; if (bus.ifid_pc4_o !== 32'h4) begin bad++; $display("FAIL rst_pc4 got=%h exp=4", bus.ifid_pc4_o); end
        total++; if (bus.ifid_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.ifid_valid_o); end
        total++; if (bus.misaligned_o !== 1'b0) begin bad++; $display("FAIL rst_mis got=%b exp=0", bus.misaligned_o); end
        total++; if (bus.fetch_count_o !== 32'h0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", bus.fetch_count_o); end
        total++; if (bus.imem_addr_o !== 6'd0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", bus.imem_addr_o); end
    endtask

    task automatic test_fetch;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        total++; if (bus.ifid_inst_o !== 32'h0000_2183) begin bad++; $display("FAIL fetch0_inst got=%h exp=00002183", bus.ifid_inst_o); end
        total++; if (bus.ifid_pc_o !== 32'h0 || bus.ifid_valid_o !== 1'b1) begin bad++; $display("FAIL fetch0_pcv got=%h/%b exp=0/1", bus.ifid_pc_o, bus.ifid_valid_o); end
        total++; if (bus.imem_addr_o !== 6'd1) begin bad++; $display("FAIL fetch0_addr got=%0d exp=1", bus.imem_addr_o); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        total++; if (bus.ifid_inst_o !== 32'h0040_2203 || bus.ifid_pc_o !== 32'h4) begin bad++; $display("FAIL fetch1 got=%h@%h exp=00402203@4", bus.ifid_inst_o, bus.ifid_pc_o); end
        total++; if (bus.fetch_count_o !== 32'd2) begin bad++; $display("FAIL fetch1_cnt got=%0d exp=2", bus.fetch_count_o); end
    endtask

    task automatic test_stall;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            total++;
            if (bus.imem_addr_o !== 6'd2 || bus.ifid_inst_o !== 32'h0040_2203 ||
                bus.ifid_pc_o !== 32'h4 || bus.fetch_count_o !== 32'd2) begin
                bad++;
                $display("FAIL stall%0d got addr=%0d inst=%h pc=%h cnt=%0d exp 2/00402203/4/2",
                         i, bus.imem_addr_o, bus.ifid_inst_o, bus.ifid_pc_o, bus.fetch_count_o);
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        total++; if (bus.ifid_inst_o !== mem[2] || bus.ifid_pc_o !== 32'h8) begin bad++; $display("FAIL stall_release got=%h@%h exp=%h@8", bus.ifid_inst_o, bus.ifid_pc_o, mem[2]); end
    endtask

    task automatic test_redirect;
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h10);
        total++; if (bus.ifid_valid_o !== 1'b0 || bus.ifid_inst_o !== NOP) begin bad++; $display("FAIL redir_bubble got=%b/%h exp=0/%h", bus.ifid_valid_o, bus.ifid_inst_o, NOP); end
        total++; if (bus.imem_addr_o !== 6'd4) begin bad++; $display("FAIL redir_addr got=%0d exp=4", bus.imem_addr_o); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        total++; if (bus.ifid_pc_o !== 32'h10 || bus.ifid_valid_o !== 1'b1) begin bad++; $display("FAIL redir_land got=%h/%b exp=10/1", bus.ifid_pc_o, bus.ifid_valid_o); end
    endtask

    task automatic test_misaligned;
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h16);
        total++; if (bus.imem_addr_o !== 6'd5 || bus.misaligned_o !== 1'b1) begin bad++; $display("FAIL mis_set got addr=%0d mis=%b exp 5/1", bus.imem_addr_o, bus.misaligned_o); end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        total++; if (bus.misaligned_o !== 1'b1) begin bad++; $display("FAIL mis_sticky got=%b exp=1", bus.misaligned_o); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        total++; if (bus.misaligned_o !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b exp=0", bus.misaligned_o); end
    endtask

    task automatic test_flush;
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h20);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        total++; if (bus.ifid_valid_o !== 1'b0 || bus.imem_addr_o !== 6'd9) begin bad++; $display("FAIL flush_run got valid=%b addr=%0d exp 0/9", bus.ifid_valid_o, bus.imem_addr_o); end
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h20);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h20);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        total++; if (bus.ifid_valid_o !== 1'b0 || bus.imem_addr_o !== 6'd8) begin bad++; $display("FAIL flush_stall got valid=%b addr=%0d exp 0/8", bus.ifid_valid_o, bus.imem_addr_o); end
    endtask

    task automatic test_reset_mid_and_alias;
        logic [31:0] cnt_before;
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFC);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h40);
        total++;
        if (bus.imem_addr_o !== 6'd0 || bus.ifid_pc_o !== 32'h0 || bus.ifid_pc4_o !== 32'h4 ||
            bus.ifid_inst_o !== NOP || bus.ifid_valid_o !== 1'b0 || bus.fetch_count_o !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid got addr=%0d pc=%h pc4=%h inst=%h v=%b cnt=%0d",
                     bus.imem_addr_o, bus.ifid_pc_o, bus.ifid_pc4_o, bus.ifid_inst_o,
                     bus.ifid_valid_o, bus.fetch_count_o);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFC);
        total++; if (bus.imem_addr_o !== 6'd63) begin bad++; $display("FAIL alias_63 got=%0d exp=63", bus.imem_addr_o); end
        cnt_before = bus.fetch_count_o;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        total++; if (bus.imem_addr_o !== 6'd0 || bus.ifid_pc_o !== 32'hFC) begin bad++; $display("FAIL alias_0 got addr=%0d pc=%h exp 0/fc", bus.imem_addr_o, bus.ifid_pc_o); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        total++; if (bus.ifid_pc_o !== 32'h100 || bus.ifid_inst_o !== mem[0] || bus.fetch_count_o !== cnt_before + 32'd2) begin bad++; $display("FAIL alias_fetch got pc=%h inst=%h cnt=%0d", bus.ifid_pc_o, bus.ifid_inst_o, bus.fetch_count_o); end
    endtask

    task automatic test_random;
        logic r, s, f, rd;
        logic [31:0] rp;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) != 0);
            s  = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 5) == 0);
            rd = ($urandom_range(0, 5) == 0);
            rp = ($urandom_range(0, 3) == 0) ? $urandom : {24'h0, 8'($urandom_range(0, 255))};
            step(r, s, f, rd, rp);
            total++;
            if (bus.imem_addr_o !== m_pc[7:2] || bus.ifid_pc_o !== m_ipc || bus.ifid_pc4_o !== m_ipc4 ||
                bus.ifid_inst_o !== m_inst || bus.ifid_valid_o !== m_valid ||
                bus.misaligned_o !== m_mis || bus.fetch_count_o !== m_cnt) begin
                bad++;
                $display("FAIL rand%0d got addr=%0d pc=%h pc4=%h inst=%h v=%b mis=%b cnt=%0d exp addr=%0d pc=%h pc4=%h inst=%h v=%b mis=%b cnt=%0d",
                         i, bus.imem_addr_o, bus.ifid_pc_o, bus.ifid_pc4_o, bus.ifid_inst_o,
                         bus.ifid_valid_o, bus.misaligned_o, bus.fetch_count_o,
                         m_pc[7:2], m_ipc, m_ipc4, m_inst, m_valid, m_mis, m_cnt);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_pc_i = 32'h0;
        m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h4; m_inst = NOP;
        m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_2183;
        mem[1] = 32'h0040_2203;

        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_misaligned();
        test_flush();
        test_reset_mid_and_alias();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline.
- Owns the program counter and drives the word address into the combinational instruction memory.
- Captures the returned instruction and its PC into the IF/ID pipeline register.
- Handles hazard-unit stalls, branch/jump redirects from EX, and bubble insertion. Downstream consumer is the decode stage.

Parameters:
- ADDR_W, 6, instruction-memory word-address width (64 words, 256 bytes).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0033, bubble instruction (add x0,x0,x0).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- stall_i  in  1  hazard-unit stall; holds PC and IF/ID.
- flush_i  in  1  load a bubble into IF/ID this cycle.
- redirect_i  in  1  taken branch/jump from EX.
- redirect_pc_i  in  32  redirect target byte address.
- imem_addr_o  out  ADDR_W  word address to instruction memory, equal to pc[ADDR_W+1:2].
- imem_data_i  in  32  instruction word returned combinationally.
- ifid_pc_o  out  32  PC of the instruction held in IF/ID.
- ifid_pc4_o  out  32  ifid_pc_o + 4.
- ifid_inst_o  out  32  instruction held in IF/ID.
- ifid_valid_o  out  1  1 = real instruction, 0 = bubble.
- misaligned_o  out  1  sticky flag: a redirect target had bits [1:0] != 0.
- fetch_count_o  out  32  count of valid instructions loaded into IF/ID.

Behaviour:
- imem_addr_o is combinational from the PC register; same-cycle instruction return. The IF/ID register adds one cycle of latency.
- Reset (rst_n=0 at a rising edge):
  - pc = RESET_PC
  - ifid_inst_o = NOP_INST
  - ifid_pc_o = 0, ifid_pc4_o = 4
  - ifid_valid_o = 0, misaligned_o = 0, fetch_count_o = 0
  - Reset overrides all other inputs, including mid-stall and mid-redirect.
- Per-edge priority: reset > redirect_i > flush_i > stall_i > normal.
- Normal:
  - pc <= pc + 4
  - IF/ID <= {pc, pc+4, imem_data_i}, valid = 1
  - fetch_count_o += 1
- stall_i only: pc and IF/ID hold; counter holds.
- redirect_i (any stall_i/flush_i):
  - pc <= {redirect_pc_i[31:2], 2'b00}
  - IF/ID <= bubble (NOP_INST, valid = 0, pc fields hold previous value)
  - If redirect_pc_i[1:0] != 0, set misaligned_o; it stays set until reset.
- flush_i without redirect:
  - IF/ID <= bubble.
  - pc advances by 4 unless stall_i, in which case pc holds.
  - Flush beats stall for IF/ID.
- Counter increments only on edges that load valid = 1. It wraps modulo 2^32.
- PC arithmetic is 32-bit, wrapping at 2^32. imem_addr_o truncates, so a PC of 256 or above aliases onto word (pc>>2) mod 64; no error is raised.
- Redirect to the current PC is legal. The instruction is refetched after a one-cycle bubble.
- Back-to-back redirects: each one takes effect. IF/ID stays a bubble for every redirect cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - NOP_INST (32'h0000_0033)
  - RESET_PC
  - opcode constants (OP_LOAD 7'b0000011, OP_STORE 7'b0100011, OP_RTYPE 7'b0110011, OP_BRANCH 7'b1100011)
  - an IF/ID bundle struct {pc, pc4, inst, valid}
- One natural sub-module: ifid_reg. It is the pipeline register with load/hold/bubble controls, reused for later stage registers.
- The PC register, next-PC mux and counter stay in if_stage.

Test Plan:
- Reset release, memory preloaded with word0 = 32'h0000_2183 and word1 = 32'h0040_2203 -> first edge: ifid_inst_o = 32'h0000_2183, ifid_pc_o = 0, valid = 1, imem_addr_o = 1. Second edge: inst = 32'h0040_2203, pc = 4, fetch_count_o = 2.
- stall_i high for 3 cycles at pc = 8 -> imem_addr_o stays 2, IF/ID unchanged, counter unchanged. On release the next edge loads the word at pc 8.
- redirect_i with redirect_pc_i = 32'h10 while stall_i = 1 -> next edge: ifid_valid_o = 0, ifid_inst_o = 32'h0000_0033, imem_addr_o = 4. Following edge: ifid_pc_o = 32'h10, valid = 1.
- redirect_pc_i = 32'h0000_0016 -> pc becomes 32'h14, misaligned_o = 1. It stays 1 after further normal fetches and clears only after rst_n = 0.
- flush_i with stall_i = 0 at pc = 32'h20 -> IF/ID bubble, pc becomes 32'h24. flush_i with stall_i = 1 -> bubble, pc holds at 32'h20.
- rst_n = 0 for one edge mid-redirect with pc = 32'hFC -> pc = 0, all outputs return to reset values. Separately, free-running from 32'hFC gives imem_addr_o = 63 then 0 (alias at 256).
